ctrl_branch_resolve: RTL and testbench



---
 rtl/ctrl_branch_resolve.sv | 167 ++++++++++++++++
 tb/tb_ctrl_branch_resolve.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_branch_resolve.sv
// Execute-side branch resolution: queues fetch-time predictions, checks them against EX outcomes,
// and drives flush/redirect/BTB-update. Optional saturating perf counters under BRU_PERF_CNT_EN.
module ctrl_branch_resolve #(
    parameter int ADDR_W   = 64,
    parameter int DEPTH    = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              if_pred_taken_i,
    input  logic [ADDR_W-1:0] if_pred_target_i,
    output logic              if_ready_o,
    input  logic              ex_valid_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_is_br_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              record_en_o,
    output logic [ADDR_W-1:0] record_pc_o,
    output logic [ADDR_W-1:0] record_target_o,
    output logic              inval_o,
    output logic              fetch_hold_o,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]       perf_br_cnt_o,
    output logic [31:0]       perf_mis_cnt_o,
`endif
    output logic              seq_err_o
);

    // Handshake: a prediction is pushed on a cycle where if_valid_i && if_ready_o;
    // if_ready_o depends only on state and fill level, never on ex_valid_i.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] q_pc  [DEPTH];
    logic              q_tk  [DEPTH];
    logic [ADDR_W-1:0] q_tgt [DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [HW-1:0] hold_cnt_q;

    logic run, empty, full, push, pop, resolve;
    logic pred_tk, act_tk, mispredict, seq_bad;

    assign run     = (state_q == RUN);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push    = if_valid_i && if_ready_o;
    assign resolve = run && ex_valid_i;
    assign pop     = resolve && !empty;

    // An empty-queue resolve is judged as if predicted not-taken.
    assign pred_tk    = !empty && q_tk[rd_ptr_q];
    assign act_tk     = ex_is_br_i && ex_taken_i;
    assign mispredict = resolve &&
                        ((pred_tk != act_tk) ||
                         (pred_tk && act_tk && (q_tgt[rd_ptr_q] != ex_target_i)));
    assign seq_bad    = resolve && (empty || (q_pc[rd_ptr_q] != ex_pc_i));

    assign if_ready_o   = run && !full;
    assign fetch_hold_o = !run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (mispredict) state_d = FLUSH;
            FLUSH:   state_d = HOLD;
            HOLD:    if (hold_cnt_q == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q == FLUSH) begin
            hold_cnt_q <= HW'(HOLD_CYC - 1);
        end else if (state_q == HOLD && hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - HW'(1);
        end
    end

    // Prediction storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]  <= if_pc_i;
            q_tk[wr_ptr_q]  <= if_pred_taken_i;
            q_tgt[wr_ptr_q] <= if_pred_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (state_q == FLUSH) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_o         <= 1'b0;
            redirect_pc_o   <= '0;
            record_en_o     <= 1'b0;
            record_pc_o     <= '0;
            record_target_o <= '0;
            inval_o         <= 1'b0;
            seq_err_o       <= 1'b0;
        end else begin
            flush_o     <= mispredict;
            record_en_o <= mispredict && act_tk;
            inval_o     <= mispredict && !act_tk;
            seq_err_o   <= seq_err_o || seq_bad;
            if (mispredict) begin
                redirect_pc_o   <= act_tk ? ex_target_i : ex_pc_i + ADDR_W'(4);
                record_pc_o     <= ex_pc_i;
                record_target_o <= ex_target_i;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt_o  <= '0;
            perf_mis_cnt_o <= '0;
        end else begin
            if (resolve && ex_is_br_i && perf_br_cnt_o != '1)
                perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
            if (mispredict && perf_mis_cnt_o != '1)
                perf_mis_cnt_o <= perf_mis_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_branch_resolve.sv
// Bench for ctrl_branch_resolve: queue-based reference model, expected-flush scoreboard, random + directed stimulus.
module tb_ctrl_branch_resolve;
    localparam int AW       = 64;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 2;
    localparam int EW       = 3 * AW + 2;

    logic          clk;
    logic          rst_n;
    logic          if_valid_i;
    logic [AW-1:0] if_pc_i;
    logic          if_pred_taken_i;
    logic [AW-1:0] if_pred_target_i;
    logic          if_ready_o;
    logic          ex_valid_i;
    logic [AW-1:0] ex_pc_i;
    logic          ex_is_br_i;
    logic          ex_taken_i;
    logic [AW-1:0] ex_target_i;
    logic          flush_o;
    logic [AW-1:0] redirect_pc_o;
    logic          record_en_o;
    logic [AW-1:0] record_pc_o;
    logic [AW-1:0] record_target_o;
    logic          inval_o;
    logic          fetch_hold_o;
    logic          seq_err_o;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]   perf_br_cnt;
    logic [31:0]   perf_mis_cnt;
`endif

    ctrl_branch_resolve #(.ADDR_W(AW), .DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_i  (if_pred_taken_i),
        .if_pred_target_i (if_pred_target_i),
        .if_ready_o       (if_ready_o),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_is_br_i       (ex_is_br_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .record_en_o      (record_en_o),
        .record_pc_o      (record_pc_o),
        .record_target_o  (record_target_o),
        .inval_o          (inval_o),
        .fetch_hold_o     (fetch_hold_o),
`ifdef BRU_PERF_CNT_EN
        .perf_br_cnt_o    (perf_br_cnt),
        .perf_mis_cnt_o   (perf_mis_cnt),
`endif
        .seq_err_o        (seq_err_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Expected flush events: {redirect, record_en, inval, record_pc, record_target}
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [AW-1:0] pc;
        logic          tk;
        logic [AW-1:0] tgt;
    } pred_t;

    pred_t mq[$];        // predictions the DUT should be holding
    int    blocked;      // cycles remaining in which the front end is held
    logic  seq_err_m;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every flush pulse must match the oldest expected event
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush_o) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fail_cnt++;
                    $display("FAIL unexpected_flush: actual flush redirect 0x%0h required no flush", redirect_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("redirect_pc", redirect_pc_o, mon_e[EW-1 -: AW]);
                    check("record_en", {63'd0, record_en_o}, {63'd0, mon_e[2*AW+1]});
                    check("inval", {63'd0, inval_o}, {63'd0, mon_e[2*AW]});
                    check("record_pc", record_pc_o, mon_e[2*AW-1 -: AW]);
                    if (mon_e[2*AW+1]) check("record_target", record_target_o, mon_e[AW-1:0]);
                end
            end else if (record_en_o || inval_o) begin
                tests_run++;
                fail_cnt++;
                $display("FAIL stray_pulse: actual record_en=%0b inval=%0b required 0 without flush",
                         record_en_o, inval_o);
            end
        end
    end

    // Driver: one clock cycle of stimulus plus the reference model's view of that cycle
    task automatic step(input logic push, input logic [AW-1:0] pc, input logic ptk, input logic [AW-1:0] ptgt,
                        input logic ex, input logic [AW-1:0] epc, input logic isbr, input logic etk,
                        input logic [AW-1:0] etgt);
        logic  ready_m, pred_tk, act_tk, mis;
        pred_t h;
        pred_t p;
        @(negedge clk);
        if_valid_i       = push;
        if_pc_i          = pc;
        if_pred_taken_i  = ptk;
        if_pred_target_i = ptgt;
        ex_valid_i       = ex;
        ex_pc_i          = epc;
        ex_is_br_i       = isbr;
        ex_taken_i       = etk;
        ex_target_i      = etgt;
        #1;
        ready_m = (blocked == 0) && (mq.size() < DEPTH);
        check("if_ready", {63'd0, if_ready_o}, {63'd0, ready_m});
        check("fetch_hold", {63'd0, fetch_hold_o}, {63'd0, blocked > 0});
        check("seq_err", {63'd0, seq_err_o}, {63'd0, seq_err_m});
        if (blocked > 0) begin
            blocked--;
        end else begin
            mis   = 1'b0;
            h.pc  = '0;
            h.tk  = 1'b0;
            h.tgt = '0;
            if (ex) begin
                if (mq.size() == 0) begin
                    seq_err_m = 1'b1;
                end else begin
                    h = mq.pop_front();
                    if (h.pc != epc) seq_err_m = 1'b1;
                end
                pred_tk = h.tk;
                act_tk  = isbr && etk;
                mis = !((!pred_tk && !act_tk) || (pred_tk && act_tk && h.tgt == etgt));
                if (mis) exp_q.push_back({act_tk ? etgt : epc + 64'd4, act_tk, !act_tk, epc, etgt});
            end
            if (push && ready_m) begin
                p.pc  = pc;
                p.tk  = ptk;
                p.tgt = ptgt;
                mq.push_back(p);
            end
            if (mis) begin
                mq.delete();
                blocked = 1 + HOLD_CYC;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic push_p(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tgt);
        step(1'b1, pc, tk, tgt, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [AW-1:0] pc, input logic isbr, input logic tk, input logic [AW-1:0] tgt);
        step(1'b0, '0, 1'b0, '0, 1'b1, pc, isbr, tk, tgt);
    endtask

    // Resolve the model's head with its predicted outcome (always correct)
    task automatic resolve_head_ok();
        resolve(mq[0].pc, 1'b1, mq[0].tk, mq[0].tgt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_valid_i = 1'b0; if_pc_i = '0; if_pred_taken_i = 1'b0; if_pred_target_i = '0;
        ex_valid_i = 1'b0; ex_pc_i = '0; ex_is_br_i = 1'b0; ex_taken_i = 1'b0; ex_target_i = '0;
        rst_n = 1'b0;
        #1;
        check("rst_flush", {63'd0, flush_o}, 64'd0);
        check("rst_redirect", redirect_pc_o, 64'd0);
        check("rst_record_en", {63'd0, record_en_o}, 64'd0);
        check("rst_record_pc", record_pc_o, 64'd0);
        check("rst_record_target", record_target_o, 64'd0);
        check("rst_inval", {63'd0, inval_o}, 64'd0);
        check("rst_fetch_hold", {63'd0, fetch_hold_o}, 64'd0);
        check("rst_seq_err", {63'd0, seq_err_o}, 64'd0);
        check("rst_if_ready", {63'd0, if_ready_o}, 64'd1);
        mq.delete();
        blocked   = 0;
        seq_err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [AW-1:0] r_pc, r_tgt, e_tgt;
    logic          r_push, r_tk, r_ex, e_br, e_tk;

    initial begin
        rst_n     = 1'b0;
        blocked   = 0;
        seq_err_m = 1'b0;
        do_reset();

        // Correct taken prediction
        push_p(64'h100, 1'b1, 64'h200);
        resolve(64'h100, 1'b1, 1'b1, 64'h200);
        idle();

        // Not-taken predicted, actually taken; fetch and resolves during flush/hold are squashed
        push_p(64'h104, 1'b0, 64'h0);
        resolve(64'h104, 1'b1, 1'b1, 64'h300);
        for (int i = 0; i < 1 + HOLD_CYC; i++)
            step(1'b1, 64'h500 + 64'(i * 4), 1'b1, 64'h600, 1'b1, 64'h500, 1'b1, 1'b0, 64'h0);
        push_p(64'h110, 1'b0, 64'h0);
        resolve(64'h110, 1'b1, 1'b0, 64'h0);

        // Taken predicted on a non-branch
        push_p(64'h108, 1'b1, 64'h400);
        resolve(64'h108, 1'b0, 1'b0, 64'h0);
        repeat (1 + HOLD_CYC) idle();

        // Fill, overflow push dropped, then concurrent push/pop across the wrap point
        for (int i = 0; i < DEPTH + 1; i++)
            push_p(64'h1000 + 64'(i * 4), 1'(i), 64'h2000 + 64'(i * 16));
        resolve_head_ok();
        for (int i = 0; i < 6; i++)
            step(1'b1, 64'h1100 + 64'(i * 4), 1'(i + 1), 64'h3000 + 64'(i * 8),
                 1'b1, mq[0].pc, 1'b1, mq[0].tk, mq[0].tgt);
        while (mq.size() > 0) resolve_head_ok();
        idle();

        // Random traffic, in-order resolutions with mixed outcomes
        for (int n = 0; n < 400; n++) begin
            r_push = 1'($urandom_range(0, 1));
            r_pc   = {$urandom, $urandom} & ~64'h3;
            r_tk   = 1'($urandom_range(0, 1));
            r_tgt  = {$urandom, $urandom} & ~64'h3;
            if (mq.size() > 0) begin
                r_ex = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) begin
                    e_br  = 1'b1;
                    e_tk  = mq[0].tk;
                    e_tgt = mq[0].tk ? mq[0].tgt : r_tgt;
                end else begin
                    e_br  = 1'($urandom_range(0, 1));
                    e_tk  = 1'($urandom_range(0, 1));
                    e_tgt = ($urandom_range(0, 1) == 0) ? mq[0].tgt : r_tgt;
                end
                step(r_push, r_pc, r_tk, r_tgt, r_ex, mq[0].pc, e_br, e_tk, e_tgt);
            end else begin
                r_ex = (blocked > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                step(r_push, r_pc, r_tk, r_tgt, r_ex, r_tgt, 1'b1, 1'b1, r_pc);
            end
        end
        while (blocked > 0) idle();
        while (mq.size() > 0) resolve_head_ok();
        idle();

        // Reset in the middle of HOLD, then the first push must be accepted
        push_p(64'h700, 1'b0, 64'h0);
        resolve(64'h700, 1'b1, 1'b1, 64'h800);
        idle();
        idle();
        do_reset();
        push_p(64'h710, 1'b1, 64'h720);
        resolve(64'h710, 1'b1, 1'b1, 64'h720);
        idle();

        // Resolve PC different from queue head
        push_p(64'h900, 1'b0, 64'h0);
        resolve(64'h904, 1'b0, 1'b0, 64'h0);
        repeat (3) idle();

        // Resolve with an empty queue, then a taken branch judged as predicted not-taken
        do_reset();
        resolve(64'hA00, 1'b0, 1'b0, 64'h0);
        repeat (3) idle();
        resolve(64'hA10, 1'b1, 1'b1, 64'hB00);
        repeat (2 + HOLD_CYC) idle();

        check("pending_flushes", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
